cw_bit_reader: RTL
==================

Name: cw_bit_reader

Overview:
- Consumes the (d, u) pair produced by the best-d stage and runs the binary-to-constant-weight encoding loop.
- Pulls message bits one at a time from a bit-serial source. Emits one run-length delta per nonzero position of the constant-weight word.
- Maintains the running (n, t) state and feeds it back to the best-d stage, so the two stages form one iteration loop of the encoder datapath.

Parameters:
- BD_LAT, 3, clock cycles from an (n, t) change at this block's outputs until valid (d, u) at its inputs. Covers theta register, multiplier and d/u register.
- N_W, 11, width of n and delta.
- T_W, 6, width of t.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse; latches n_init/t_init and begins encoding (ignored unless IDLE or DONE)
- n_init  in  N_W  initial code length
- t_init  in  T_W  initial weight
- n  out  N_W  current remaining length, to best-d stage
- t  out  T_W  current remaining weight, to best-d stage
- d  in  10  best-d run length, power of two
- u  in  4  log2(d)
- bit_in  in  1  message bit
- bit_valid  in  1  bit_in valid
- bit_ready  out  1  bit_in consumed when bit_valid && bit_ready
- delta  out  N_W  gap to next nonzero position
- delta_valid  out  1  delta valid; held until delta_ready
- delta_ready  in  1  downstream accept
- busy  out  1  high from start until DONE
- done  out  1  high in DONE state until next start
- err  out  1  sticky error; cleared by start or reset

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE; n=0, t=0, delta=0, delta_valid=0, bit_ready=0, busy=0, done=0, err=0; internal acc=0, wait counter=0, index=0. Reset mid-operation aborts immediately and drops any pending delta.
- States: IDLE, WAIT_D, READ_FLAG, READ_IDX, EMIT, DONE.
- IDLE/DONE + start: n<=n_init, t<=t_init, acc<=0, err<=0, done<=0, busy<=1.
  - If t_init==0, go to DONE (done=1, no deltas).
  - Else go to WAIT_D, wait counter loaded with BD_LAT.
- WAIT_D: decrement counter each cycle; at 0 go to READ_FLAG. Every n/t update re-enters WAIT_D; d/u is sampled only in READ_FLAG/READ_IDX.
- READ_FLAG: bit_ready=1; stall while bit_valid=0. On handshake:
  - bit=1 and d<n: n<=n-d, acc<=acc+d, go to WAIT_D.
  - bit=1 and d>=n: err<=1, go to DONE.
  - bit=0: latch u into a remaining-bits counter, index<=0.
    - u==0: go to EMIT with i=0.
    - Otherwise go to READ_IDX.
- READ_IDX: bit_ready=1. Each handshake does index<=(index<<1)|bit_in (MSB first) and decrements the counter. After the u-th bit, go to EMIT.
- EMIT: entry cycle computes i=index.
  - If i>=n: err<=1, go to DONE, no delta.
  - Else: delta<=acc+i, delta_valid<=1, n<=n-i-1, t<=t-1, acc<=0.
  - Hold delta/delta_valid until delta_ready. On accept, delta_valid<=0.
  - Then go to DONE if new t==0, else WAIT_D.
  - delta_ready high on the same cycle delta_valid rises counts as accepted that cycle.
- bit_ready is 0 in every state other than READ_FLAG/READ_IDX. Bits are never consumed outside those states.
- Arithmetic: all unsigned. acc+i cannot exceed n_init (fits N_W). No wrap permitted; the err checks guard subtraction underflow.
- start while busy: ignored.
- start in DONE: restarts and clears err/done.
- bit_valid toggling low mid-index: stall, index preserved.

Test Plan:
- n_init=16, t_init=1, bits 0,1,0,1 (d=8,u=3): one delta=5, then n=10, t=0, done=1, err=0, exactly 4 bits consumed.
- n_init=16, t_init=1, bits 1,0,1,1 (d=8, then d=4,u=2 after n=8): delta=11, final n=4, t=0, done=1.
- Multi-weight n_init=1024, t_init=4 against a best-d model: exactly 4 deltas, sum(deltas)+4 <= 1024, t reaches 0, done=1. Compare every delta and n/t against a C reference.
- Backpressure: delta_ready held low 10 cycles during EMIT: delta stable, delta_valid high, bit_ready=0, no n/t change until accept.
- Forced d>=n (stub d=16 with n=16) and bit=1 -> err=1, done=1, no delta. Following start clears err.
- Reset asserted mid READ_IDX: next cycle all outputs at reset values, state IDLE. A subsequent start runs cleanly.

Source files
------------

// File: rtl/cw_bit_reader.sv
// Binary-to-constant-weight encoder loop: pulls message bits serially, turns
// them into run-length deltas, and feeds (n, t) back to the best-d stage.
module cw_bit_reader #(
   parameter int BD_LAT = 3,
   parameter int N_W    = 11,
   parameter int T_W    = 6
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [N_W-1:0] n_init,
   input  logic [T_W-1:0] t_init,
   output logic [N_W-1:0] n,
   output logic [T_W-1:0] t,
   input  logic [9:0]     d,
   input  logic [3:0]     u,
   input  logic           bit_in,
   input  logic           bit_valid,
   output logic           bit_ready,
   output logic [N_W-1:0] delta,
   output logic           delta_valid,
   input  logic           delta_ready,
   output logic           busy,
   output logic           done,
   output logic           err
);

   // One counter serves both the best-d latency wait and the index bit count.
   localparam int CNT_W = ($clog2(BD_LAT + 1) > 4) ? $clog2(BD_LAT + 1) : 4;

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT_D, S_READ_FLAG, S_READ_IDX, S_EMIT, S_DONE
   } state_e;

   state_e           state_q, state_d;
   logic [N_W-1:0]   n_q, n_d;
   logic [T_W-1:0]   t_q, t_d;
   logic [N_W-1:0]   acc_q, acc_d;
   logic [N_W-1:0]   idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [N_W-1:0]   delta_q, delta_d;
   logic             dvld_q, dvld_d;
   logic             err_q, err_d;
   logic [N_W-1:0]   d_ext;

   assign d_ext       = N_W'(d);
   assign n           = n_q;
   assign t           = t_q;
   assign delta       = delta_q;
   assign delta_valid = dvld_q;
   assign err         = err_q;
   assign bit_ready   = (state_q == S_READ_FLAG) || (state_q == S_READ_IDX);
   assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
   assign done        = (state_q == S_DONE);

   // Next-state and datapath updates for the encoding loop.
   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      t_d     = t_q;
      acc_d   = acc_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      delta_d = delta_q;
      dvld_d  = dvld_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               n_d   = n_init;
               t_d   = t_init;
               acc_d = '0;
               err_d = 1'b0;
               if (t_init == '0) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_WAIT_D;
                  cnt_d   = CNT_W'(BD_LAT);
               end
            end
         end
         S_WAIT_D: begin
            // Give the best-d stage time to settle on the current (n, t).
            if (cnt_q == '0) state_d = S_READ_FLAG;
            else             cnt_d   = cnt_q - 1'b1;
         end
         S_READ_FLAG: begin
            if (bit_valid) begin
               if (bit_in) begin
                  if (d_ext < n_q) begin
                     n_d     = n_q - d_ext;
                     acc_d   = acc_q + d_ext;
                     state_d = S_WAIT_D;
                     cnt_d   = CNT_W'(BD_LAT);
                  end else begin
                     err_d   = 1'b1;
                     state_d = S_DONE;
                  end
               end else begin
                  cnt_d   = CNT_W'(u);
                  idx_d   = '0;
                  state_d = (u == 4'd0) ? S_EMIT : S_READ_IDX;
               end
            end
         end
         S_READ_IDX: begin
            if (bit_valid) begin
               idx_d = {idx_q[N_W-2:0], bit_in};
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == CNT_W'(1)) state_d = S_EMIT;
            end
         end
         S_EMIT: begin
            // dvld_q low means this is the entry cycle; accept leaves EMIT.
            if (!dvld_q) begin
               if (idx_q >= n_q) begin
                  err_d   = 1'b1;
                  state_d = S_DONE;
               end else begin
                  delta_d = acc_q + idx_q;
                  dvld_d  = 1'b1;
                  n_d     = n_q - idx_q - 1'b1;
                  t_d     = t_q - 1'b1;
                  acc_d   = '0;
               end
            end else if (delta_ready) begin
               dvld_d = 1'b0;
               if (t_q == '0) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_WAIT_D;
                  cnt_d   = CNT_W'(BD_LAT);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State register with synchronous reset; reset drops any pending delta.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         n_q     <= '0;
         t_q     <= '0;
         acc_q   <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         delta_q <= '0;
         dvld_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         t_q     <= t_d;
         acc_q   <= acc_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         delta_q <= delta_d;
         dvld_q  <= dvld_d;
         err_q   <= err_d;
      end
   end

endmodule
